// File: rtl/riscv_lsu.sv
// Load/store unit: issues one data-memory transaction per memory instruction and stalls the core until rvalid.
// Optional macro LSU_MISALIGN_EN adds lsu_misaligned_o and suppresses misaligned halfword/word accesses.
module riscv_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic [31:0]       lsu_data_o,
    output logic              lsu_stall_req_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [31:0]       data_wdata_o,
    input  logic [31:0]       data_rdata_i,
    input  logic              data_rvalid_i
`ifdef LSU_MISALIGN_EN
    ,
    output logic              lsu_misaligned_o
`endif
);

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t     state;
    logic [2:0] size_q;
    logic [1:0] off_q;
    logic       we_q;
    logic       misaligned;
    logic       issue;
    logic       complete;

    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << off;
            LDST_H, LDST_HU: be = off[1] ? 4'b1100 : 4'b0011;
            LDST_W:          be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] wd;
        wd = wdata;
        case (size)
            LDST_B, LDST_BU: wd = {4{wdata[7:0]}};
            LDST_H, LDST_HU: wd = {2{wdata[15:0]}};
            default:         wd = wdata;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b   = $signed(rdata[8*off +: 8]);
        h   = off[1] ? $signed(rdata[31:16]) : $signed(rdata[15:0]);
        res = 32'd0;
        case (size)
            LDST_B:  res = 32'(b);
            LDST_BU: res = {24'd0, b};
            LDST_H:  res = 32'(h);
            LDST_HU: res = {16'd0, h};
            LDST_W:  res = rdata;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_EN
    assign misaligned = (state == S_IDLE) && lsu_req_i &&
                        ((((lsu_size_i == LDST_H) || (lsu_size_i == LDST_HU)) && lsu_addr_i[0]) ||
                         ((lsu_size_i == LDST_W) && (lsu_addr_i[1:0] != 2'b00)));
    assign lsu_misaligned_o = misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign issue    = (state == S_IDLE) && lsu_req_i && !misaligned;
    assign complete = (state == S_WAIT) && data_rvalid_i;

    // Memory-side request is only driven during the single issue cycle.
    assign data_req_o   = issue;
    assign data_we_o    = issue && lsu_we_i;
    assign data_be_o    = issue ? be_gen(lsu_size_i, lsu_addr_i[1:0]) : 4'b0000;
    assign data_addr_o  = issue ? {lsu_addr_i[ADDR_W-1:2], 2'b00} : '0;
    assign data_wdata_o = issue ? wdata_gen(lsu_size_i, lsu_wdata_i) : 32'd0;

    assign lsu_stall_req_o = issue || ((state == S_WAIT) && !data_rvalid_i);
    assign lsu_data_o      = (complete && !we_q) ? load_ext(size_q, off_q, data_rdata_i) : 32'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            size_q <= 3'd0;
            off_q  <= 2'd0;
            we_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state  <= S_WAIT;
                        size_q <= lsu_size_i;
                        off_q  <= lsu_addr_i[1:0];
                        we_q   <= lsu_we_i;
                    end
                end
                S_WAIT: begin
                    if (data_rvalid_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed testbench for riscv_lsu: loads, stores, delayed rvalid, reset in WAIT, misalignment.
module tb_riscv_lsu;

    localparam int ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              lsu_req_i;
    logic              lsu_we_i;
    logic [2:0]        lsu_size_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [31:0]       lsu_wdata_i;
    logic [31:0]       lsu_data_o;
    logic              lsu_stall_req_o;
    logic              data_req_o;
    logic              data_we_o;
    logic [3:0]        data_be_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [31:0]       data_wdata_o;
    logic [31:0]       data_rdata_i;
    logic              data_rvalid_i;
`ifdef LSU_MISALIGN_EN
    logic              lsu_misaligned_o;
`endif

    int checks = 0;
    int errors = 0;
    int stall_cnt;
    int req_cnt;

    always #5 clk_i = ~clk_i;

    riscv_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_wdata_i     (lsu_wdata_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_rdata_i    (data_rdata_i),
        .data_rvalid_i   (data_rvalid_i)
`ifdef LSU_MISALIGN_EN
        ,
        .lsu_misaligned_o(lsu_misaligned_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        lsu_req_i   = req;
        lsu_we_i    = we;
        lsu_size_i  = size;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'd0, data_req_o},      32'd0);
        check({tag, "_we"},    {31'd0, data_we_o},       32'd0);
        check({tag, "_be"},    {28'd0, data_be_o},       32'd0);
        check({tag, "_addr"},  data_addr_o,              32'd0);
        check({tag, "_wdata"}, data_wdata_o,             32'd0);
        check({tag, "_stall"}, {31'd0, lsu_stall_req_o}, 32'd0);
        check({tag, "_data"},  lsu_data_o,               32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        data_rdata_i = 32'd0;
        data_rvalid_i = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check_all_zero("reset");

        // Word load at 0x100
        tick();
        drive(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        #1;
        check("lw_req",   {31'd0, data_req_o},      32'd1);
        check("lw_be",    {28'd0, data_be_o},       32'hF);
        check("lw_addr",  data_addr_o,              32'h100);
        check("lw_we",    {31'd0, data_we_o},       32'd0);
        check("lw_stall", {31'd0, lsu_stall_req_o}, 32'd1);
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hDEADBEEF;
        #1;
        check("lw_req_wait", {31'd0, data_req_o},      32'd0);
        check("lw_stall_rv", {31'd0, lsu_stall_req_o}, 32'd0);
        check("lw_data",     lsu_data_o,               32'hDEADBEEF);
        tick();
        data_rvalid_i = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check_all_zero("idle_after_lw");

        // LB then back-to-back LBU at 0x103
        drive(1'b1, 1'b0, 3'd0, 32'h103, 32'd0);
        #1;
        check("lb_be", {28'd0, data_be_o}, 32'h8);
        check("lb_addr", data_addr_o, 32'h100);
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h80123456;
        #1;
        check("lb_data", lsu_data_o, 32'hFFFFFF80);
        tick();
        data_rvalid_i = 1'b0;
        drive(1'b1, 1'b0, 3'd4, 32'h103, 32'd0);
        #1;
        check("lbu_req", {31'd0, data_req_o}, 32'd1);
        check("lbu_be",  {28'd0, data_be_o},  32'h8);
        tick();
        data_rvalid_i = 1'b1;
        #1;
        check("lbu_data", lsu_data_o, 32'h00000080);
        tick();
        data_rvalid_i = 1'b0;

        // Store halfword at 0x202
        drive(1'b1, 1'b1, 3'd1, 32'h202, 32'h1234ABCD);
        #1;
        check("sh_be",    {28'd0, data_be_o},       32'hC);
        check("sh_wdata", data_wdata_o,             32'hABCDABCD);
        check("sh_we",    {31'd0, data_we_o},       32'd1);
        check("sh_addr",  data_addr_o,              32'h200);
        check("sh_stall", {31'd0, lsu_stall_req_o}, 32'd1);
        tick();
        #1;
        check("sh_stall_wait", {31'd0, lsu_stall_req_o}, 32'd1);
        check("sh_we_wait",    {31'd0, data_we_o},       32'd0);
        check("sh_req_wait",   {31'd0, data_req_o},      32'd0);
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFFFFFF;
        #1;
        check("sh_stall_rv", {31'd0, lsu_stall_req_o}, 32'd0);
        check("sh_data",     lsu_data_o,               32'd0);
        tick();
        data_rvalid_i = 1'b0;

        // Byte store replicates the low byte
        drive(1'b1, 1'b1, 3'd0, 32'h301, 32'h000000A5);
        #1;
        check("sb_be",    {28'd0, data_be_o}, 32'h2);
        check("sb_wdata", data_wdata_o,       32'hA5A5A5A5);
        tick();
        data_rvalid_i = 1'b1;
        tick();
        data_rvalid_i = 1'b0;

        // Word load with rvalid 5 cycles after issue
        drive(1'b1, 1'b0, 3'd2, 32'h40, 32'd0);
        #1;
        stall_cnt = int'(lsu_stall_req_o);
        req_cnt   = int'(data_req_o);
        for (int i = 1; i < 5; i++) begin
            tick();
            #1;
            stall_cnt += int'(lsu_stall_req_o);
            req_cnt   += int'(data_req_o);
        end
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0BADF00D;
        #1;
        stall_cnt += int'(lsu_stall_req_o);
        req_cnt   += int'(data_req_o);
        check("delay_data",      lsu_data_o,       32'h0BADF00D);
        check("delay_stall_cnt", 32'(stall_cnt),   32'd5);
        check("delay_req_cnt",   32'(req_cnt),     32'd1);

        // Back-to-back LH at 0x106, then LHU at 0x100
        tick();
        data_rvalid_i = 1'b0;
        drive(1'b1, 1'b0, 3'd1, 32'h106, 32'd0);
        #1;
        check("lh_req", {31'd0, data_req_o}, 32'd1);
        check("lh_be",  {28'd0, data_be_o},  32'hC);
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h80010000;
        #1;
        check("lh_data", lsu_data_o, 32'hFFFF8001);
        tick();
        data_rvalid_i = 1'b0;
        drive(1'b1, 1'b0, 3'd5, 32'h100, 32'd0);
        #1;
        check("lhu_be", {28'd0, data_be_o}, 32'h3);
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1234F00D;
        #1;
        check("lhu_data", lsu_data_o, 32'h0000F00D);
        tick();
        data_rvalid_i = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        // Reset while waiting, then a late rvalid
        drive(1'b1, 1'b0, 3'd2, 32'h300, 32'd0);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hFFFFFFFF;
        #1;
        check_all_zero("rst_wait");
        tick();
        #1;
        check_all_zero("late_rvalid");
        data_rvalid_i = 1'b0;
        drive(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        #1;
        check("post_rst_req", {31'd0, data_req_o}, 32'd1);
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h11223344;
        #1;
        check("post_rst_data", lsu_data_o, 32'h11223344);
        tick();
        data_rvalid_i = 1'b0;

        // Word access at 0x101
        drive(1'b1, 1'b0, 3'd2, 32'h101, 32'd0);
        #1;
`ifdef LSU_MISALIGN_EN
        check("mis_flag",  {31'd0, lsu_misaligned_o}, 32'd1);
        check("mis_req",   {31'd0, data_req_o},       32'd0);
        check("mis_stall", {31'd0, lsu_stall_req_o},  32'd0);
        check("mis_data",  lsu_data_o,                32'd0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check_all_zero("mis_idle");
`else
        check("unal_req",  {31'd0, data_req_o}, 32'd1);
        check("unal_addr", data_addr_o,         32'h100);
        check("unal_be",   {28'd0, data_be_o},  32'hF);
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hCAFEF00D;
        #1;
        check("unal_data", lsu_data_o, 32'hCAFEF00D);
        tick();
        data_rvalid_i = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check_all_zero("unal_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
